// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit CPU: opcodes, exec FSM states, exec output payload.
package cpu_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_W      = 3;
  localparam int unsigned IMM_W      = 9;
  localparam int unsigned OP_W       = 4;
  localparam int unsigned MUL_CYCLES = 16;  // one shift-add per multiplier bit, so equals DATA_W

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_MUL   = 4'h8,
    OP_LI    = 4'h9,
    OP_ADDI6 = 4'hA,
    OP_LD    = 4'hB,
    OP_ST    = 4'hC,
    OP_ADDI  = 4'hE
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] wdata;
    logic              reg_we;
    logic              mem_rd;
    logic              mem_wr;
    logic              trap;
  } exec_out_t;

  // Sign-extend the 6-bit offset field
  function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
    return {{(DATA_W-6){v[5]}}, v};
  endfunction

  // Sign-extend the full 9-bit immediate
  function automatic logic [DATA_W-1:0] sext9(input logic [IMM_W-1:0] v);
    return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one step per cycle, low DATA_W bits of a*b.
module exec_mul_iter
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES);

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;

  // Operand latch on start, then one shift-add per cycle; done holds until next start
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else if (busy) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU / address generation with a registered valid/ready output.
// Optional iterative multiply is enabled by defining EXEC_MUL_EN; otherwise MUL traps.
module exec_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_wdata,
  output logic              out_reg_we,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic              out_trap
);

  exec_out_t out_q;
  exec_out_t out_d;
  exec_out_t dec_c;
  op_e       op_c;
  logic      accept_c;

  assign op_c     = op_e'(in_op);
  assign accept_c = in_valid && in_ready;

  // Single-cycle result for the incoming instruction
  always_comb begin
    dec_c        = '0;
    dec_c.valid  = 1'b1;
    dec_c.rd     = in_rd;
    dec_c.reg_we = 1'b1;
    case (op_c)
      OP_NOP:   dec_c.reg_we = 1'b0;
      OP_ADD:   dec_c.result = in_a + in_b;
      OP_SUB:   dec_c.result = in_a - in_b;
      OP_AND:   dec_c.result = in_a & in_b;
      OP_OR:    dec_c.result = in_a | in_b;
      OP_XOR:   dec_c.result = in_a ^ in_b;
      OP_SHL:   dec_c.result = in_a << in_b[3:0];
      OP_SHR:   dec_c.result = in_a >> in_b[3:0];
      OP_LI:    dec_c.result = DATA_W'(in_imm);
      OP_ADDI6: dec_c.result = in_a + sext6(in_imm[5:0]);
      OP_LD: begin
        dec_c.result = in_a + sext6(in_imm[5:0]);
        dec_c.mem_rd = 1'b1;
      end
      OP_ST: begin
        dec_c.result = in_a + sext6(in_imm[5:0]);
        dec_c.wdata  = in_b;
        dec_c.reg_we = 1'b0;
        dec_c.mem_wr = 1'b1;
      end
      OP_ADDI:  dec_c.result = in_a + sext9(in_imm);
`ifdef EXEC_MUL_EN
      OP_MUL:   dec_c.result = '0;  // real result comes from the multiplier
`endif
      default: begin
        dec_c.trap   = 1'b1;
        dec_c.reg_we = 1'b0;
      end
    endcase
  end

`ifdef EXEC_MUL_EN
  state_e            state_q;
  state_e            state_d;
  logic [REG_W-1:0]  mul_rd_q;
  logic              mul_start_c;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;

  exec_mul_iter u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_c),
    .a       (in_a),
    .b       (in_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign in_ready = (state_q == S_IDLE) && (!out_q.valid || out_ready);

  // Next state and output-register load
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_d.valid = out_q.valid && !out_ready;
    mul_start_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (op_c == OP_MUL) begin
            mul_start_c = 1'b1;
            state_d     = S_MUL;
          end else begin
            out_d = dec_c;
          end
        end
      end
      S_MUL: begin
        // finished product waits only if the slot is still occupied
        if (mul_done && !mul_busy && (!out_q.valid || out_ready)) begin
          out_d        = '0;
          out_d.valid  = 1'b1;
          out_d.rd     = mul_rd_q;
          out_d.result = mul_prod;
          out_d.reg_we = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and destination index of the multiply in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mul_rd_q <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start_c) mul_rd_q <= in_rd;
    end
  end
`else
  assign in_ready = !out_q.valid || out_ready;

  // Output-register load: new result or release of the consumed one
  always_comb begin
    out_d       = out_q;
    out_d.valid = out_q.valid && !out_ready;
    if (accept_c) out_d = dec_c;
  end
`endif

  // Output register toward writeback
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out_valid  = out_q.valid;
  assign out_rd     = out_q.rd;
  assign out_result = out_q.result;
  assign out_wdata  = out_q.wdata;
  assign out_reg_we = out_q.reg_we;
  assign out_mem_rd = out_q.mem_rd;
  assign out_mem_wr = out_q.mem_wr;
  assign out_trap   = out_q.trap;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed cases, then randomized traffic with backpressure.
`timescale 1ns/1ps
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_rd;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [8:0]  in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_rd;
  logic [15:0] out_result;
  logic [15:0] out_wdata;
  logic        out_reg_we;
  logic        out_mem_rd;
  logic        out_mem_wr;
  logic        out_trap;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] result;
    logic [15:0] wdata;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        trap;
  } exp_t;

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  exp_t q[$];
  exp_t mon_act;
  exp_t mon_exp;
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_rdy = 1'b0;

  exec_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .out_result (out_result),
    .out_wdata  (out_wdata),
    .out_reg_we (out_reg_we),
    .out_mem_rd (out_mem_rd),
    .out_mem_wr (out_mem_wr),
    .out_trap   (out_trap)
  );

  always #5 clk = ~clk;

  // Reference model: instruction semantics in plain integer arithmetic
  function automatic exp_t model(input int op, input int rd, input int a, input int b, input int imm);
    exp_t   e;
    longint res = 0;
    longint s6  = ((imm & 63) >= 32) ? longint'(imm & 63) - 64 : longint'(imm & 63);
    longint s9  = (imm >= 256) ? longint'(imm) - 512 : longint'(imm);
    e = '0;
    e.rd = 3'(rd);
    e.reg_we = 1'b1;
    case (op)
      0:  e.reg_we = 1'b0;
      1:  res = longint'(a) + b;
      2:  res = longint'(a) - b;
      3:  res = a & b;
      4:  res = a | b;
      5:  res = a ^ b;
      6:  res = longint'(a) * (longint'(1) << (b % 16));
      7:  res = a / (1 << (b % 16));
      8:  if (MUL_EN) res = longint'(a) * longint'(b);
          else begin e.trap = 1'b1; e.reg_we = 1'b0; end
      9:  res = imm;
      10: res = a + s6;
      11: begin res = a + s6; e.mem_rd = 1'b1; end
      12: begin res = a + s6; e.wdata = 16'(b); e.mem_wr = 1'b1; e.reg_we = 1'b0; end
      14: res = a + s9;
      default: begin e.trap = 1'b1; e.reg_we = 1'b0; end
    endcase
    e.result = 16'(res % 65536);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one instruction and hold it until accepted; expected result goes to the scoreboard
  task automatic issue(input int op, input int rd, input int a, input int b, input int imm);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    in_valid = 1'b1;
    in_op    = 4'(op);
    in_rd    = 3'(rd);
    in_a     = 16'(a);
    in_b     = 16'(b);
    in_imm   = 9'(imm);
    do begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: op %0d not accepted within 200 cycles", op);
    end else begin
      q.push_back(model(op, rd, a, b, imm));
    end
  endtask

  // Monitor: every handshake on the output pops and compares one expected result
  initial forever begin
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
      mon_act = {out_rd, out_result, out_wdata, out_reg_we, out_mem_rd, out_mem_wr, out_trap};
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got rd=%0d result=%h, expected nothing", out_rd, out_result);
      end else begin
        mon_exp = q.pop_front();
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL scoreboard: got rd=%0d res=%h wd=%h we=%b mr=%b mw=%b tr=%b expected rd=%0d res=%h wd=%h we=%b mr=%b mw=%b tr=%b",
                   mon_act.rd, mon_act.result, mon_act.wdata, mon_act.reg_we, mon_act.mem_rd, mon_act.mem_wr, mon_act.trap,
                   mon_exp.rd, mon_exp.result, mon_exp.wdata, mon_exp.reg_we, mon_exp.mem_rd, mon_exp.mem_wr, mon_exp.trap);
        end
      end
    end
  end

  // Random writeback backpressure
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_a = '0; in_b = '0; in_imm = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_fields", 64'({out_rd, out_result, out_wdata, out_reg_we, out_mem_rd, out_mem_wr, out_trap}), 64'd0);

    // LI / ADDI / SUB
    issue(9, 1, 0, 0, 1);
    chk("li_valid", 64'(out_valid), 64'd1);
    chk("li_rd", 64'(out_rd), 64'd1);
    chk("li_result", 64'(out_result), 64'd1);
    chk("li_reg_we", 64'(out_reg_we), 64'd1);
    issue(14, 2, 20, 0, 4);
    chk("addi_result", 64'(out_result), 64'd24);
    issue(2, 3, 5, 7, 0);
    chk("sub_result", 64'(out_result), 64'hFFFE);

    // Backpressure: held result, then handoff and accept on the same edge
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(1, 4, 3, 4, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", 64'({out_rd, out_result}), 64'({3'd4, 16'd7}));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b1; in_op = 4'd1; in_rd = 3'd5; in_a = 16'd10; in_b = 16'd20;
    out_ready = 1'b1;
    #1;
    chk("handoff_in_ready", 64'(in_ready), 64'd1);
    issue(1, 5, 10, 20, 0);
    chk("handoff_new_result", 64'({out_valid, out_rd, out_result}), 64'({1'b1, 3'd5, 16'd30}));

    // Trap and store with the same operands
    issue(15, 6, 16'h10, 16'hABCD, 9'h03F);
    chk("trap_flag", 64'(out_trap), 64'd1);
    chk("trap_we_res", 64'({out_reg_we, out_result}), 64'd0);
    issue(12, 7, 16'h10, 16'hABCD, 9'h03F);
    chk("st_addr", 64'(out_result), 64'h000F);
    chk("st_wdata", 64'(out_wdata), 64'hABCD);
    chk("st_ctl", 64'({out_mem_wr, out_reg_we, out_mem_rd}), 64'b100);

    // Multiply latency
    issue(8, 1, 300, 300, 0);
`ifdef EXEC_MUL_EN
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk("mul_busy", 64'({in_ready, out_valid}), 64'd0);
    end
    @(posedge clk); #1;
    chk("mul_done_valid", 64'(out_valid), 64'd1);
    chk("mul_result", 64'(out_result), 64'd24464);
`else
    chk("mul_trap", 64'({out_trap, out_reg_we, out_result}), 64'({1'b1, 1'b0, 16'd0}));
`endif

    // Reset in the fifth cycle after a MUL is accepted
    @(posedge clk); #1;
    issue(8, 2, 1234, 5678, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    issue(9, 3, 0, 0, 9'h1FF);
    chk("post_rst_li", 64'({out_valid, out_rd, out_result}), 64'({1'b1, 3'd3, 16'h01FF}));

    // Randomized traffic
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
            int'($urandom & 32'hFFFF), int'($urandom & 32'hFFFF), int'($urandom & 32'h1FF));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int w = 0; w < 200 && q.size() > 0; w++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
